// File: rtl/rfile_host.sv
// rfile_host: host-side initiator for the RSSI localization engine (RFILE).
//
// Streams 16-word job records from a job memory into the engine's anchor,
// RSSI and reference-value inputs, and writes every (xt, yt) result to a
// result memory in job order.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, job_cnt        batch start pulse and job count (0..2^JOB_W)
//   mem_rd, mem_addr      job memory read strobe and {job, word} address
//   mem_rdata             read data, valid the cycle after mem_rd
//   A_x..C_y              anchor coordinates to the engine (8 bit)
//   rssiA..rssiC          RSSI values to the engine (20 bit)
//   valueA..valueC        reference values to the engine (16 bit)
//   busy                  engine busy, monitored only
//   out_valid, xt, yt     engine result pulse and result
//   res_we, res_addr,     result write strobe, job index and {xt, yt}
//   res_data
//   host_busy, done       batch in progress, end-of-batch pulse
//
// Handshakes: none of the interfaces carry a ready. mem_rd is a request the
// memory always accepts; the word returns exactly one cycle later. out_valid
// is a one-cycle pulse from the engine that must be acted on at that edge;
// res_we is a one-cycle write the result memory always accepts.
//
// Job inputs are double-buffered: a shadow set is fetched while the engine
// works on the active set, and the shadow is promoted to the engine outputs
// on an out_valid edge, so the engine sees the next job from its RECV cycle.
module rfile_host #(
  parameter int JOB_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [JOB_W:0]    job_cnt,
  output logic              mem_rd,
  output logic [JOB_W+3:0]  mem_addr,
  input  logic [19:0]       mem_rdata,
  output logic [7:0]        A_x,
  output logic [7:0]        A_y,
  output logic [7:0]        B_x,
  output logic [7:0]        B_y,
  output logic [7:0]        C_x,
  output logic [7:0]        C_y,
  output logic [19:0]       rssiA,
  output logic [19:0]       rssiB,
  output logic [19:0]       rssiC,
  output logic [15:0]       valueA,
  output logic [15:0]       valueB,
  output logic [15:0]       valueC,
  input  logic              busy,
  input  logic              out_valid,
  input  logic [7:0]        xt,
  input  logic [7:0]        yt,
  output logic              res_we,
  output logic [JOB_W-1:0]  res_addr,
  output logic [15:0]       res_data,
  output logic              host_busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;
  state_t state, state_nx;

  logic [JOB_W:0]   job_cnt_q;
  logic [JOB_W-1:0] fetch_idx;
  logic [JOB_W-1:0] active_idx;
  logic [3:0]       rd_cnt;      // next word to request, 12 = all requested
  logic             pend_vld;    // a read issued last cycle lands now
  logic [3:0]       pend_word;
  logic             shadow_full;
  logic             active_valid;

  logic [7:0]  sh_ax, sh_ay, sh_bx, sh_by, sh_cx, sh_cy;
  logic [19:0] sh_ra, sh_rb, sh_rc;
  logic [15:0] sh_va, sh_vb, sh_vc;

  logic start_ok, last_land, more_jobs, refetch, last_write;

  // The engine busy flag plays no part in control.
  logic unused_ok;
  assign unused_ok = &{1'b0, busy};

  assign start_ok   = start && !host_busy && (state == S_IDLE);
  assign last_land  = pend_vld && (pend_word == 4'd11);
  assign more_jobs  = ({1'b0, fetch_idx} + (JOB_W+1)'(1)) < job_cnt_q;
  assign refetch    = (state == S_HOLD) && !shadow_full && more_jobs;
  assign last_write = res_we && host_busy &&
                      ({1'b0, res_addr} == (job_cnt_q - (JOB_W+1)'(1)));

  assign mem_rd   = (state == S_FETCH) && (rd_cnt < 4'd12);
  assign mem_addr = mem_rd ? {fetch_idx, rd_cnt} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok && (job_cnt != '0)) state_nx = S_FETCH;
      S_FETCH: if (last_land) state_nx = S_HOLD;
      S_HOLD:  if (!shadow_full) state_nx = more_jobs ? S_FETCH : S_DRAIN;
      S_DRAIN: if (last_write) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (last_write) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt_q <= '0; fetch_idx <= '0; active_idx <= '0; rd_cnt <= '0;
      pend_vld <= 1'b0; pend_word <= '0;
      shadow_full <= 1'b0; active_valid <= 1'b0;
      sh_ax <= '0; sh_ay <= '0; sh_bx <= '0; sh_by <= '0; sh_cx <= '0; sh_cy <= '0;
      sh_ra <= '0; sh_rb <= '0; sh_rc <= '0; sh_va <= '0; sh_vb <= '0; sh_vc <= '0;
      A_x <= '0; A_y <= '0; B_x <= '0; B_y <= '0; C_x <= '0; C_y <= '0;
      rssiA <= '0; rssiB <= '0; rssiC <= '0;
      valueA <= '0; valueB <= '0; valueC <= '0;
      res_we <= 1'b0; res_addr <= '0; res_data <= '0;
      host_busy <= 1'b0; done <= 1'b0;
    end else begin
      done      <= 1'b0;
      res_we    <= 1'b0;
      pend_vld  <= mem_rd;
      pend_word <= rd_cnt;
      if (mem_rd) rd_cnt <= rd_cnt + 4'd1;

      if (start_ok) begin
        job_cnt_q <= job_cnt;
        fetch_idx <= '0;
        rd_cnt    <= '0;
        if (job_cnt == '0) done <= 1'b1;
        else               host_busy <= 1'b1;
      end

      if (refetch) begin
        fetch_idx <= fetch_idx + (JOB_W)'(1);
        rd_cnt    <= '0;
      end

      if (pend_vld) begin
        case (pend_word)
          4'd0:    sh_ax <= mem_rdata[7:0];
          4'd1:    sh_ay <= mem_rdata[7:0];
          4'd2:    sh_bx <= mem_rdata[7:0];
          4'd3:    sh_by <= mem_rdata[7:0];
          4'd4:    sh_cx <= mem_rdata[7:0];
          4'd5:    sh_cy <= mem_rdata[7:0];
          4'd6:    sh_ra <= mem_rdata;
          4'd7:    sh_rb <= mem_rdata;
          4'd8:    sh_rc <= mem_rdata;
          4'd9:    sh_va <= mem_rdata[15:0];
          4'd10:   sh_vb <= mem_rdata[15:0];
          4'd11:   sh_vc <= mem_rdata[15:0];
          default: ;
        endcase
      end

      // Result capture first, then promotion. shadow_full is only set after
      // word 11 has landed, so a partially written shadow is never promoted.
      if (out_valid) begin
        if (active_valid) begin
          res_we   <= 1'b1;
          res_addr <= active_idx;
          res_data <= {xt, yt};
        end
        if (shadow_full) begin
          A_x <= sh_ax; A_y <= sh_ay; B_x <= sh_bx; B_y <= sh_by;
          C_x <= sh_cx; C_y <= sh_cy;
          rssiA <= sh_ra; rssiB <= sh_rb; rssiC <= sh_rc;
          valueA <= sh_va; valueB <= sh_vb; valueC <= sh_vc;
          active_idx   <= fetch_idx;
          active_valid <= 1'b1;
          shadow_full  <= 1'b0;
        end else begin
          // Engine reruns on held inputs; that result must be dropped.
          active_valid <= 1'b0;
        end
      end

      if (last_land) shadow_full <= 1'b1;

      if (last_write) begin
        done      <= 1'b1;
        host_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rfile_host.sv
module tb_rfile_host;
  localparam int JOB_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [JOB_W:0]    job_cnt;
  logic              mem_rd;
  logic [JOB_W+3:0]  mem_addr;
  logic [19:0]       mem_rdata;
  logic [7:0]        A_x, A_y, B_x, B_y, C_x, C_y;
  logic [19:0]       rssiA, rssiB, rssiC;
  logic [15:0]       valueA, valueB, valueC;
  logic              busy;
  logic              out_valid;
  logic [7:0]        xt, yt;
  logic              res_we;
  logic [JOB_W-1:0]  res_addr;
  logic [15:0]       res_data;
  logic              host_busy;
  logic              done;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rfile_host #(.JOB_W(JOB_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .job_cnt(job_cnt),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .A_x(A_x), .A_y(A_y), .B_x(B_x), .B_y(B_y), .C_x(C_x), .C_y(C_y),
    .rssiA(rssiA), .rssiB(rssiB), .rssiC(rssiC),
    .valueA(valueA), .valueB(valueB), .valueC(valueC),
    .busy(busy), .out_valid(out_valid), .xt(xt), .yt(yt),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .host_busy(host_busy), .done(done)
  );

  // ---------------- job memory model ----------------
  logic [19:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n)      mem_rdata <= '0;
    else if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // ---------------- monitors (logging only) ----------------
  logic [19:0]  res_log[$];     // {res_addr, res_data}
  logic [155:0] swap_log[$];
  logic [155:0] bundle, prev_bundle;
  logic         ov_edge;
  bit           stab_en = 1'b0;
  int           stab_err = 0;
  int           rd_count = 0;
  int           max_rd_job = 0;
  int           done_cnt = 0;

  assign bundle = {A_x, A_y, B_x, B_y, C_x, C_y, rssiA, rssiB, rssiC,
                   valueA, valueB, valueC};

  always @(posedge clk) ov_edge = out_valid;

  always @(negedge clk) begin
    if (res_we) res_log.push_back({res_addr, res_data});
    if (mem_rd) begin
      rd_count++;
      if (int'(mem_addr[7:4]) > max_rd_job) max_rd_job = int'(mem_addr[7:4]);
    end
    if (done) done_cnt++;
    if (stab_en && (bundle !== prev_bundle)) begin
      if (!ov_edge) stab_err++;
      swap_log.push_back(bundle);
    end
    prev_bundle = bundle;
  end

  // ---------------- expected-value model ----------------
  function automatic logic [155:0] exp_bundle(input int j);
    int b;
    b = j * 16;
    return {mem[b][7:0], mem[b+1][7:0], mem[b+2][7:0], mem[b+3][7:0],
            mem[b+4][7:0], mem[b+5][7:0], mem[b+6], mem[b+7], mem[b+8],
            mem[b+9][15:0], mem[b+10][15:0], mem[b+11][15:0]};
  endfunction

  // Behavioural engine result: derived from the inputs it was given.
  function automatic logic [15:0] exp_res(input int j);
    int b;
    b = j * 16;
    return {mem[b][7:0] ^ mem[b+4][7:0], mem[b+6][7:0] ^ mem[b+11][15:8]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [JOB_W:0] n);
    @(negedge clk);
    job_cnt = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_engine(input int period, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      out_valid = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if ((c % period) == period - 1) begin
        out_valid = 1'b1;
        xt = A_x ^ C_x;
        yt = rssiA[7:0] ^ valueC[15:8];
      end
    end
    out_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; job_cnt = '0; out_valid = 1'b0;
    xt = '0; yt = '0; busy = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bundle !== '0) begin fails++; $display("FAIL reset_engine_inputs got=%h exp=0", bundle); end
    tests++; if ({mem_rd, res_we, host_busy, done} !== 4'b0) begin fails++; $display("FAIL reset_strobes got=%b exp=0000", {mem_rd, res_we, host_busy, done}); end
    tests++; if ({mem_addr, res_addr, res_data} !== '0) begin fails++; $display("FAIL reset_addr_data got=%h exp=0", {mem_addr, res_addr, res_data}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int r0;
    mem[0] = 20'd10;  mem[1] = 20'd20;  mem[2] = 20'd200;
    mem[3] = 20'd30;  mem[4] = 20'd100; mem[5] = 20'd220;
    r0 = rd_count;
    pulse_start(5'd1);
    tests++; if (host_busy !== 1'b1) begin fails++; $display("FAIL single_host_busy got=%b exp=1", host_busy); end
    tests++; if ({mem_rd, mem_addr} !== {1'b1, 8'h00}) begin fails++; $display("FAIL single_first_read got=%h exp=100", {mem_rd, mem_addr}); end
    @(negedge clk);
    tests++; if (mem_addr !== 8'h01) begin fails++; $display("FAIL single_second_addr got=%h exp=01", mem_addr); end
    repeat (15) @(negedge clk);
    tests++; if (rd_count - r0 !== 12) begin fails++; $display("FAIL single_read_count got=%0d exp=12", rd_count - r0); end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL single_hold_no_read got=%b exp=0", mem_rd); end
    out_valid = 1'b1; xt = 8'd55; yt = 8'd66;
    @(negedge clk);
    out_valid = 1'b0;
    tests++; if (res_we !== 1'b0) begin fails++; $display("FAIL single_prime_no_write got=%b exp=0", res_we); end
    tests++; if ({A_x, A_y, B_x, B_y, C_x, C_y} !== {8'd10, 8'd20, 8'd200, 8'd30, 8'd100, 8'd220})
      begin fails++; $display("FAIL single_anchors got=%h exp=0a14c81e64dc", {A_x, A_y, B_x, B_y, C_x, C_y}); end
    repeat (4) @(negedge clk);
    out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    tests++; if ({res_we, res_addr, res_data} !== {1'b1, 4'd0, 16'h3742}) begin fails++; $display("FAIL single_result got=%h exp=103742", {res_we, res_addr, res_data}); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_early got=%b exp=0", done); end
    @(negedge clk);
    tests++; if ({done, host_busy, res_we} !== 3'b100) begin fails++; $display("FAIL single_done got=%b exp=100", {done, host_busy, res_we}); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid_fetch;
    int d0, r0;
    d0 = done_cnt;
    pulse_start(5'd2);
    repeat (4) @(negedge clk);
    tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL midrst_fetching got=%b exp=1", mem_rd); end
    rst_n = 1'b0;
    #1;
    tests++; if ({mem_rd, host_busy, done, res_we} !== 4'b0) begin fails++; $display("FAIL midrst_strobes got=%b exp=0000", {mem_rd, host_busy, done, res_we}); end
    tests++; if (bundle !== '0) begin fails++; $display("FAIL midrst_engine_inputs got=%h exp=0", bundle); end
    tests++; if ({mem_addr, res_data} !== '0) begin fails++; $display("FAIL midrst_addr_data got=%h exp=0", {mem_addr, res_data}); end
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rd_count;
    repeat (30) @(negedge clk);
    tests++; if (done_cnt !== d0) begin fails++; $display("FAIL midrst_no_done got=%0d exp=%0d", done_cnt, d0); end
    tests++; if (rd_count !== r0) begin fails++; $display("FAIL midrst_no_reads got=%0d exp=%0d", rd_count, r0); end
  endtask

  task automatic test_zero_jobs;
    int d0, r0;
    d0 = done_cnt; r0 = rd_count;
    pulse_start(5'd0);
    tests++; if ({done, host_busy} !== 2'b10) begin fails++; $display("FAIL zero_done got=%b exp=10", {done, host_busy}); end
    @(negedge clk);
    tests++; if ({done, host_busy} !== 2'b00) begin fails++; $display("FAIL zero_done_width got=%b exp=00", {done, host_busy}); end
    repeat (3) @(negedge clk);
    tests++; if (rd_count !== r0) begin fails++; $display("FAIL zero_no_reads got=%0d exp=%0d", rd_count, r0); end
    tests++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL zero_done_count got=%0d exp=%0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_busy_start;
    int r0;
    bit ok;
    res_log.delete();
    r0 = rd_count; max_rd_job = 0;
    pulse_start(5'd2);
    repeat (3) @(negedge clk);
    job_cnt = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; job_cnt = '0;
    run_engine(20, 400, ok);
    repeat (2) @(negedge clk);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL busy_done_timeout got=%b exp=1", ok); end
    tests++; if (res_log.size() !== 2) begin fails++; $display("FAIL busy_result_count got=%0d exp=2", res_log.size()); end
    for (int j = 0; j < 2 && j < res_log.size(); j++) begin
      tests++; if (res_log[j] !== {4'(j), exp_res(j)}) begin fails++; $display("FAIL busy_result%0d got=%h exp=%h", j, res_log[j], {4'(j), exp_res(j)}); end
    end
    tests++; if (rd_count - r0 !== 24) begin fails++; $display("FAIL busy_read_count got=%0d exp=24", rd_count - r0); end
    tests++; if (max_rd_job > 1) begin fails++; $display("FAIL busy_max_job got=%0d exp<=1", max_rd_job); end
  endtask

  task automatic test_stream16;
    bit ok;
    logic [19:0] exp_q[$];
    res_log.delete();
    for (int j = 0; j < 16; j++) exp_q.push_back({4'(j), exp_res(j)});
    pulse_start(5'd16);
    run_engine(8, 3000, ok);
    repeat (2) @(negedge clk);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stream_done_timeout got=%b exp=1", ok); end
    tests++; if (res_log.size() !== 16) begin fails++; $display("FAIL stream_result_count got=%0d exp=16", res_log.size()); end
    for (int j = 0; j < 16 && j < res_log.size(); j++) begin
      tests++; if (res_log[j] !== exp_q[j]) begin fails++; $display("FAIL stream_result%0d got=%h exp=%h", j, res_log[j], exp_q[j]); end
    end
  endtask

  task automatic test_stability4;
    bit ok;
    res_log.delete(); swap_log.delete(); stab_err = 0;
    pulse_start(5'd4);
    stab_en = 1'b1;
    run_engine(20, 600, ok);
    repeat (2) @(negedge clk);
    stab_en = 1'b0;
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stab_done_timeout got=%b exp=1", ok); end
    tests++; if (stab_err !== 0) begin fails++; $display("FAIL stab_inputs_moved got=%0d exp=0", stab_err); end
    tests++; if (swap_log.size() !== 4) begin fails++; $display("FAIL stab_swap_count got=%0d exp=4", swap_log.size()); end
    for (int j = 0; j < 4 && j < swap_log.size(); j++) begin
      tests++; if (swap_log[j] !== exp_bundle(j)) begin fails++; $display("FAIL stab_swap%0d got=%h exp=%h", j, swap_log[j], exp_bundle(j)); end
    end
    tests++; if (res_log.size() !== 4) begin fails++; $display("FAIL stab_result_count got=%0d exp=4", res_log.size()); end
    for (int j = 0; j < 4 && j < res_log.size(); j++) begin
      tests++; if (res_log[j] !== {4'(j), exp_res(j)}) begin fails++; $display("FAIL stab_result%0d got=%h exp=%h", j, res_log[j], {4'(j), exp_res(j)}); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 20'(a * 4099 + 12345);
    test_reset();
    test_single();
    test_reset_mid_fetch();
    test_zero_jobs();
    test_busy_start();
    test_stream16();
    test_stability4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
